// File: rtl/conv_psum_accum.sv
// Per-lane partial-sum accumulator for one conv output tile: sums MAC products,
// adds a broadcast bias, optionally clamps negatives and saturates to DW bits.
module conv_psum_accum #(
    parameter int LANES = 112,
    parameter int DW    = 16,
    parameter int ACC_W = 24,
    parameter int CNT_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      term_total,
    input  logic [DW-1:0]         bias,
    input  logic                  relu_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_data,
    output logic                  busy,
    output logic                  done
);

    localparam int SAT_HI = (2 ** (DW - 1)) - 1;
    localparam int SAT_LO = -(2 ** (DW - 1));

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         term_reg;
    logic [CNT_W-1:0]         cnt;
    logic signed [DW-1:0]     bias_reg;
    logic                     relu_reg;
    logic signed [ACC_W-1:0]  acc [LANES];
    logic                     beat;
    logic                     last_beat;
    logic                     tile_start;

    // Bias is added one bit wider than the accumulator so the sum itself cannot wrap.
    function automatic logic signed [ACC_W:0] bias_sum(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [DW-1:0] b);
        return (ACC_W + 1)'(a) + (ACC_W + 1)'(b);
    endfunction

    function automatic logic signed [DW-1:0] relu_sat(input logic signed [ACC_W:0] s,
                                                      input logic relu);
        logic signed [ACC_W:0] v;
        v = (relu && (s < 0)) ? '0 : s;
        if (v > (ACC_W + 1)'(SAT_HI))
            v = (ACC_W + 1)'(SAT_HI);
        else if (v < (ACC_W + 1)'(SAT_LO))
            v = (ACC_W + 1)'(SAT_LO);
        return DW'(v);
    endfunction

    assign tile_start = (state == IDLE) && start;
    assign beat       = (state == ACCUM) && in_valid;
    assign last_beat  = beat && ((cnt + CNT_W'(1)) == term_reg);
    assign in_ready   = (state == ACCUM);
    assign out_valid  = (state == OUT);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (term_total != '0) ? ACCUM : BIAS;
            ACCUM:   if (last_beat) state_nxt = BIAS;
            BIAS:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            done     <= 1'b0;
            term_reg <= '0;
            bias_reg <= '0;
            relu_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == OUT) && out_ready;
            if (tile_start) begin
                term_reg <= term_total;
                bias_reg <= $signed(bias);
                relu_reg <= relu_en;
                cnt      <= '0;
            end else if (beat) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Accumulate stage, then bias/ReLU/saturate into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
            out_data <= '0;
        end else begin
            if (tile_start) begin
                for (int i = 0; i < LANES; i++) acc[i] <= '0;
            end else if (beat) begin
                for (int i = 0; i < LANES; i++)
                    acc[i] <= acc[i] + ACC_W'($signed(in_data[i*DW +: DW]));
            end
            if (state == BIAS) begin
                for (int i = 0; i < LANES; i++)
                    out_data[i*DW +: DW] <= relu_sat(bias_sum(acc[i], bias_reg), relu_reg);
            end
        end
    end

endmodule

// File: tb/tb_conv_psum_accum.sv
// Bench for conv_psum_accum: directed vector table, hand sequences for
// backpressure/reset/start corner cases, and random tiles against an arithmetic model.
module tb_conv_psum_accum;

    localparam int LANES = 112;
    localparam int DW    = 16;
    localparam int ACC_W = 24;
    localparam int CNT_W = 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [CNT_W-1:0]     term_total = '0;
    logic [DW-1:0]        bias = '0;
    logic                 relu_en = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [LANES*DW-1:0]  in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [LANES*DW-1:0]  out_data;
    logic                 busy;
    logic                 done;

    conv_psum_accum #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .term_total(term_total), .bias(bias),
        .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [LANES*DW-1:0]   beats [$];
    logic signed [DW-1:0]  exp_lane [LANES];

    typedef struct {
        int          term;
        logic [15:0] b;
        logic        r;
        logic [15:0] p0, p1, p2;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fill_const(input int n, input logic [15:0] p);
        beats.delete();
        for (int k = 0; k < n; k++) beats.push_back({LANES{p}});
    endtask

    task automatic fill_rand(input int n);
        logic [LANES*DW-1:0] w;
        beats.delete();
        for (int k = 0; k < n; k++) begin
            for (int l = 0; l < LANES; l++) w[l*DW +: DW] = 16'($urandom);
            beats.push_back(w);
        end
    endtask

    task automatic set_exp_const(input logic [15:0] v);
        for (int l = 0; l < LANES; l++) exp_lane[l] = v;
    endtask

    // Plain integer reference: sum, wrap to the accumulator width, add bias, clamp.
    task automatic model(input int term, input logic signed [15:0] b, input logic r);
        longint s;
        logic signed [15:0] v;
        for (int l = 0; l < LANES; l++) begin
            s = 0;
            for (int k = 0; k < term; k++) begin
                v = beats[k][l*DW +: DW];
                s += v;
            end
            s = ((s % (64'sd1 << ACC_W)) + (64'sd1 << ACC_W)) % (64'sd1 << ACC_W);
            if (s >= (64'sd1 << (ACC_W - 1))) s -= (64'sd1 << ACC_W);
            s += b;
            if (r && s < 0) s = 0;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            exp_lane[l] = 16'(s);
        end
    endtask

    task automatic run_tile(input int term, input logic [15:0] b, input logic r,
                            input int bubble, input int hold, input bit poke_start,
                            input string name);
        int idx, cyc, n, nbad, first;
        bit stable;
        logic [LANES*DW-1:0] snap;
        @(negedge clk);
        start = 1'b1; term_total = CNT_W'(term); bias = b; relu_en = r;
        @(posedge clk);
        idx = 0; cyc = 0;
        while (idx < term && cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 0) chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
            if (poke_start && cyc == 0) begin
                start = 1'b1; term_total = CNT_W'(term + 5); bias = ~b; relu_en = ~r;
            end
            cyc++;
            in_data  = beats[idx];
            in_valid = ($urandom_range(99) >= bubble) || (cyc > 1000);
            @(posedge clk);
            if (in_valid) idx++;
        end
        if (cyc >= 2000) chk({name, "_beat_timeout"}, 64'(idx), 64'(term));
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b0;
            n++;
        end while (!out_valid && n < 10);
        chk({name, "_latency"}, 64'(n), 64'd2);
        chk({name, "_ctrl_out"}, {61'd0, in_ready, busy, done}, 64'b010);
        nbad = 0; first = -1;
        for (int l = 0; l < LANES; l++)
            if (out_data[l*DW +: DW] !== exp_lane[l]) begin
                nbad++;
                if (first < 0) first = l;
            end
        if (first < 0) first = 0;
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL %s_data lane=%0d actual=%h required=%h bad_lanes=%0d",
                     name, first, out_data[first*DW +: DW], exp_lane[first], nbad);
        end
        if (hold > 0) begin
            snap = out_data; stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (out_data !== snap || !out_valid || in_ready || done) stable = 1'b0;
            end
            chk({name, "_hold_stable"}, 64'(stable), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_done_pulse"}, {62'd0, done, out_valid}, 64'b10);
        @(negedge clk);
        chk({name, "_done_once"}, 64'(done), 64'd0);
    endtask

    vec_t vt [9];

    initial begin
        vt[0] = '{3, 16'h0000, 1'b0, 16'h0100, 16'h0200, 16'hFF00, 16'h0200};
        vt[1] = '{2, 16'h0100, 1'b1, 16'hF000, 16'hF000, 16'h0000, 16'h0000};
        vt[2] = '{2, 16'h0100, 1'b0, 16'hF000, 16'hF000, 16'h0000, 16'hE100};
        vt[3] = '{0, 16'h0080, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0080};
        vt[4] = '{0, 16'h8000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vt[5] = '{0, 16'h8000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
        vt[6] = '{3, 16'h7FFF, 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vt[7] = '{3, 16'h8000, 1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        vt[8] = '{1, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ctrl", {60'd0, in_ready, out_valid, busy, done}, 64'd0);
        chk("reset_data", 64'(out_data != '0), 64'd0);

        for (int v = 0; v < 9; v++) begin
            beats.delete();
            if (vt[v].term > 0) beats.push_back({LANES{vt[v].p0}});
            if (vt[v].term > 1) beats.push_back({LANES{vt[v].p1}});
            if (vt[v].term > 2) beats.push_back({LANES{vt[v].p2}});
            set_exp_const(vt[v].exp);
            run_tile(vt[v].term, vt[v].b, vt[v].r, 0, 0, 1'b0, $sformatf("vec%0d", v));
        end

        // 25 full-scale beats: large but unwrapped sum, saturates on output.
        fill_const(25, 16'h7FFF);
        set_exp_const(16'h7FFF);
        run_tile(25, 16'h0000, 1'b0, 0, 0, 1'b0, "sat25");

        // Bubbles plus an ignored start pulse mid-accumulation.
        fill_rand(3);
        model(3, 16'sh0123, 1'b0);
        run_tile(3, 16'h0123, 1'b0, 50, 0, 1'b1, "bubble_start");

        // Output backpressure for 10 cycles.
        fill_rand(4);
        model(4, -16'sh0040, 1'b1);
        run_tile(4, 16'hFFC0, 1'b1, 0, 10, 1'b0, "backpressure");

        // Reset after two of five beats discards the partial tile.
        fill_const(5, 16'h1234);
        @(negedge clk);
        start = 1'b1; term_total = 10'd5; bias = 16'h0000; relu_en = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; in_data = beats[k];
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_accum_ctrl", {60'd0, in_ready, out_valid, busy, done}, 64'd0);
        fill_const(1, 16'h0010);
        set_exp_const(16'h0010);
        run_tile(1, 16'h0000, 1'b0, 0, 0, 1'b0, "after_rst1");
        beats.delete();
        set_exp_const(16'h0080);
        run_tile(0, 16'h0080, 1'b0, 0, 0, 1'b0, "after_rst0");

        // Reset while out_valid is held: no done pulse, outputs cleared.
        @(negedge clk);
        start = 1'b1; term_total = 10'd0; bias = 16'h0005; relu_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_out_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_ctrl", {61'd0, out_valid, busy, done}, 64'd0);
        chk("rst_out_data", 64'(out_data != '0), 64'd0);
        @(negedge clk);
        chk("rst_out_no_done", 64'(done), 64'd0);

        // Random tiles against the reference model.
        for (int t = 0; t < 20; t++) begin
            int          term;
            logic [15:0] b;
            logic        r;
            term = $urandom_range(6);
            b    = 16'($urandom);
            r    = 1'($urandom);
            fill_rand(term);
            model(term, b, r);
            run_tile(term, b, r, 30, $urandom_range(3), 1'b0, $sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
